// File: rtl/risc_pkg.sv
// risc_pkg: shared widths and constants for the fetch stage
package risc_pkg;
  localparam int INST_W = 32;
  localparam int JIDX_W = 26;
  localparam logic [INST_W-1:0] NOP = 32'h0;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/inst_mem.sv
// inst_mem: IMEM_DEPTH x 32 instruction memory, sync read with enable, one write port
module inst_mem
  import risc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  output logic [INST_W-1:0] rdata
);
  logic [INST_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC/fetch stage with stall, branch and jump redirect
// BRANCH_DELAY_SLOT_EN: when defined, the redirect cycle still issues the fetch of F
module inst_fetch
  import risc_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              jmp_en,
  input  logic [JIDX_W-1:0] jmp_index,
  input  logic              imem_we,
  input  logic [AW-1:0]     imem_waddr,
  input  logic [INST_W-1:0] imem_wdata,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              cnt
);
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  logic [31:0] f, f_next, tgt;
  logic [INST_W-1:0] rdata;
  logic redir, fetch, squash;
  always_comb begin
    redir = jmp_en | br_taken;
    tgt = jmp_en ? {pc_plus4[31:28], jmp_index, 2'b00} : br_target & ~32'h3;
    fetch = DS ? (!stall || redir) : (!stall && !redir);
    squash = !DS && redir;
    f_next = redir ? tgt : fetch ? f + 32'd4 : f;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      f <= RESET_PC;
      pc <= '0;
      pc_plus4 <= '0;
      cnt <= 1'b0;
    end else begin
      f <= f_next;
      if (fetch) begin
        pc <= f;
        pc_plus4 <= f + 32'd4;
        cnt <= 1'b1;
      end else if (squash) cnt <= 1'b0;
    end
  end
  // a cleared cnt masks the held memory output, so reset and squash read as NOP
  assign inst = cnt ? rdata : NOP;
  inst_mem #(.DEPTH(IMEM_DEPTH)) u_mem (
    .clk(clk),
    .re(fetch),
    .raddr(f[AW+1:2]),
    .we(imem_we),
    .waddr(imem_waddr),
    .wdata(imem_wdata),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a behavioural fetch model
module tb_inst_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, stall = 1'b0, br_taken = 1'b0, jmp_en = 1'b0, imem_we = 1'b0;
  logic [31:0] br_target = '0, imem_wdata = '0;
  logic [25:0] jmp_index = '0;
  logic [7:0] imem_waddr = '0;
  logic [31:0] inst, pc, pc_plus4, inst2, pc2, pp42;
  logic cnt, cnt2;
  inst_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp_en(jmp_en), .jmp_index(jmp_index), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .inst(inst), .pc(pc), .pc_plus4(pc_plus4), .cnt(cnt)
  );
  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp_en(jmp_en), .jmp_index(jmp_index), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .inst(inst2), .pc(pc2), .pc_plus4(pp42), .cnt(cnt2)
  );
  typedef struct {logic [31:0] inst, pc, pp4; logic cnt;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] m [256];
  logic [31:0] mf = 32'h0, ei = 32'h0, ep = 32'h0, epp = 32'h0;
  logic ec = 1'b0;
  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("mon_cnt", {31'b0, cnt}, {31'b0, e.cnt});
      chk("mon_inst", inst, e.inst);
      chk("mon_pc", pc, e.pc);
      chk("mon_pc_plus4", pc_plus4, e.pp4);
    end
  end
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] bt,
                      input bit j, input logic [25:0] ji, input bit we,
                      input logic [7:0] wa, input logic [31:0] wd);
    logic [31:0] t;
    @(negedge clk);
    rst = r; stall = s; br_taken = b; br_target = bt; jmp_en = j; jmp_index = ji;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    if (r) begin
      mf = 32'h0; ei = 32'h0; ep = 32'h0; epp = 32'h0; ec = 1'b0;
    end else if (j || b) begin
      t = j ? ((epp & 32'hF000_0000) | ({6'b0, ji} * 4)) : (bt / 4) * 4;
`ifdef BRANCH_DELAY_SLOT_EN
      ei = m[(mf / 4) % 256]; ep = mf; epp = mf + 4; ec = 1'b1;
`else
      ei = 32'h0; ec = 1'b0;
`endif
      mf = t;
    end else if (!s) begin
      ei = m[(mf / 4) % 256]; ep = mf; epp = mf + 4; ec = 1'b1; mf = mf + 4;
    end
    if (we) m[wa] = wd;
    q.push_back('{ei, ep, epp, ec});
    @(posedge clk);
    #2;
  endtask
  task automatic go(); step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic reset1(); step(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  initial begin
    logic [31:0] a [4];
    for (int i = 0; i < 4; i++) a[i] = 32'hA0A0_0000 + i;
    for (int i = 0; i < 256; i++) step(1, 0, 0, 0, 0, 0, 1, 8'(i), i < 4 ? a[i] : $urandom);
    chk("rst_cnt", {31'b0, cnt}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    reset1();
    for (int i = 0; i < 4; i++) begin
      go();
      chk("seq_inst", inst, a[i]);
      chk("seq_pc", pc, 32'(4 * i));
      chk("seq_cnt", {31'b0, cnt}, 32'h1);
    end
    reset1(); go(); go();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("stall_inst", inst, a[1]);
      chk("stall_pc", pc, 32'h4);
    end
    go();
    chk("stall_release_inst", inst, a[2]);
    reset1(); go(); go();
    step(0, 0, 1, 32'h0000_0041, 0, 0, 0, 0, 0);
`ifdef BRANCH_DELAY_SLOT_EN
    chk("br_slot_inst", inst, a[2]);
    chk("br_slot_pc", pc, 32'h8);
`else
    chk("br_squash_cnt", {31'b0, cnt}, 32'h0);
    chk("br_squash_inst", inst, 32'h0);
`endif
    go();
    chk("br_target_pc", pc, 32'h40);
    step(0, 0, 1, 32'h1000_0000, 0, 0, 0, 0, 0);
    go(); go();
    chk("pre_jmp_pc_plus4", pc_plus4, 32'h1000_0008);
    step(0, 0, 1, 32'h0000_0200, 1, 26'h10, 0, 0, 0);
    go();
    chk("jmp_pc", pc, 32'h1000_0040);
    step(1, 1, 1, 32'h0000_0080, 0, 0, 0, 0, 0);
    chk("midrst_cnt", {31'b0, cnt}, 32'h0);
    chk("midrst_cnt2", {31'b0, cnt2}, 32'h0);
    go();
    chk("midrst_first_pc", pc, 32'h0);
    chk("midrst_first_inst", inst, a[0]);
    chk("midrst_first_cnt", {31'b0, cnt}, 32'h1);
    chk("wrap_pc0", pc2, 32'hFFFF_FFFC);
    chk("wrap_inst0", inst2, m[255]);
    chk("wrap_pc_plus4", pp42, 32'h0);
    go();
    chk("wrap_pc1", pc2, 32'h0);
    chk("wrap_inst1", inst2, a[0]);
    for (int i = 0; i < 400; i++)
      step($urandom_range(49) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
           $urandom, $urandom_range(11) == 0, 26'($urandom), $urandom_range(5) == 0,
           8'($urandom), $urandom);
    go(); go();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, words of instruction memory (power of two).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port stall  input  1  hold the fetch state and outputs.
REQ-006 SHALL have port br_taken  input  1  redirect to br_target.
REQ-007 SHALL have port br_target  input  32  branch byte address.
REQ-008 SHALL have port jmp_en  input  1  redirect to the jump target.
REQ-009 SHALL have port jmp_index  input  26  jump word index.
REQ-010 SHALL have port imem_we  input  1  instruction-memory load strobe.
REQ-011 SHALL have port imem_waddr  input  log2(IMEM_DEPTH)  load word address.
REQ-012 SHALL have port imem_wdata  input  32  load data.
REQ-013 SHALL have port inst  output  32  fetched instruction, to the decoder inst input.
REQ-014 SHALL have port pc  output  32  byte address of inst.
REQ-015 SHALL have port pc_plus4  output  32  pc + 4.
REQ-016 SHALL have port cnt  output  1  inst valid, to the decoder cnt input.

Function
REQ-017 SHALL keep an internal fetch pointer F, the byte address of the next word to fetch.
REQ-018 SHALL read imem word F[log2(IMEM_DEPTH)+1:2] each cycle; upper address bits are ignored (aliasing).
REQ-019 SHALL, when no redirect and no stall: inst<=imem[F], pc<=F, pc_plus4<=F+4, cnt<=1, F<=F+4.
REQ-020 SHALL give a latency of exactly one cycle from F to inst, pc and cnt.
REQ-021 SHALL wrap F+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 SHALL, when stall=1 and no redirect: hold F, inst, pc, pc_plus4 and cnt unchanged.
REQ-023 SHALL, when jmp_en=1: set F<={pc_plus4[31:28], jmp_index, 2'b00}, using the current registered pc_plus4.
REQ-024 SHALL, when br_taken=1 and jmp_en=0: set F<={br_target[31:2], 2'b00}, forcing the low 2 bits to zero.
REQ-025 SHALL give jmp_en priority over br_taken when both are 1.
REQ-026 SHALL give a redirect priority over stall; a redirect is never lost.
REQ-027 SHALL apply the output-register behaviour during a redirect cycle as set by REQ-033.
REQ-028 SHALL write imem_wdata to imem_waddr when imem_we=1, regardless of stall or rst.
REQ-029 SHALL return the old data when a read and a write hit the same word in one cycle.

Reset
REQ-030 SHALL, on rst=1 at a clock edge: F<=RESET_PC, inst<=32'h0, pc<=32'h0, pc_plus4<=32'h0, cnt<=0.
REQ-031 SHALL give rst priority over stall, redirect and the fetch step; imem contents are not cleared.
REQ-032 SHALL output imem[RESET_PC] with cnt=1 on the first edge after rst falls, with stall=0.

Configuration
REQ-033 SHALL support macro BRANCH_DELAY_SLOT_EN. Defined: a redirect cycle performs the normal fetch of F (inst<=imem[F], cnt<=1, pc<=F) and then loads the target into F. Undefined: a redirect cycle squashes that fetch (inst<=32'h0 NOP, cnt<=0, pc and pc_plus4 hold) and then loads the target into F.

Structure
REQ-034 SHALL place the NOP constant (32'h0), the instruction width (32), the jump-index width (26) and the RESET_PC default in shared package risc_pkg.
REQ-035 SHALL implement the instruction memory as sub-module inst_mem: synchronous read, one write port, IMEM_DEPTH x 32.

Verification
REQ-036 SHALL check sequential fetch: imem[0..3]=A0..A3, reset then run -> inst=A0,A1,A2,A3 on consecutive cycles; pc=0,4,8,12; cnt=1.
REQ-037 SHALL check stall: assert stall for 3 cycles while inst=A1 -> inst=A1, pc=4 held; after release inst=A2.
REQ-038 SHALL check branch: br_taken=1, br_target=32'h0000_0041 while pc=4.
  - Without BRANCH_DELAY_SLOT_EN: next cycle cnt=0, inst=0; following cycle pc=32'h40.
  - With BRANCH_DELAY_SLOT_EN: next cycle inst=A2 (pc=8); following cycle pc=32'h40.
REQ-039 SHALL check jump vs branch: jmp_en=1, jmp_index=26'h10 and br_taken=1 together while pc_plus4=32'h1000_0008 -> fetch resumes at pc=32'h1000_0040.
REQ-040 SHALL check reset mid-run and wrap-around.
  - rst=1 during a stall with a pending branch -> next cycle cnt=0, F=RESET_PC; first valid inst=imem[RESET_PC].
  - RESET_PC=32'hFFFF_FFFC -> pc sequence FFFF_FFFC, 0000_0000.
